mic_fir_arbiter: RTL and testbench
==================================

# mic_fir_arbiter

Time-multiplexes one shared FIR low-pass instance across the four I2S microphone channels. Round-robin arbitration over four per-microphone AXI-stream sample inputs; one 24-bit sample per grant forwarded to the FIR input stream. The FIR produces results in order. A tag FIFO of channel ids steers each filtered 16-bit result back to its per-channel output. Sits between the per-mic I2S receivers and the downstream decimation/FFT stage.

## Interface
Parameters:
- N_CH, 4, number of microphone channels (2..8)
- IN_W, 24, input sample width (signed)
- OUT_W, 16, FIR result width (signed)
- TAG_DEPTH, 16, tag FIFO depth (power of two, ≥2)

Ports:
- clk_in  input  1  system clock; all logic on posedge
- rst_n_in  input  1  asynchronous, active-low reset
- s_tdata  input  N_CH*IN_W  channel i sample in bits [i*IN_W +: IN_W]
- s_tvalid  input  N_CH  per-channel sample valid
- s_tready  output  N_CH  per-channel accept; at most one bit high per cycle
- fir_tdata  output  IN_W  sample to shared FIR
- fir_tvalid  output  1  FIR input valid (registered)
- fir_tready  input  1  FIR input ready
- fir_res_tdata  input  OUT_W  FIR result
- fir_res_tvalid  input  1  FIR result valid (no backpressure)
- ch_data  output  N_CH*OUT_W  last result per channel, held
- ch_valid  output  N_CH  one-cycle pulse per new result
- busy  output  1  tag FIFO non-empty or fir_tvalid high
- tag_err  output  1  sticky error flag (only with MIC_ARB_TAG_CHECK_EN)

## Operation
- Clock and reset: one clock, clk_in; reset is asynchronous and active-low on rst_n_in.
- FSM: IDLE (fir_tvalid=0) and HOLD (fir_tvalid=1, beat pending).
- can_issue = (state==IDLE or fir_tready) and tag_count<TAG_DEPTH.
- Grant g = first channel with s_tvalid, searching from last_grant+1 modulo N_CH. s_tready[g]=can_issue; all others 0.
- On accept (s_tvalid[g]&s_tready[g]): fir_tdata<=s_tdata[g], push g, last_grant<=g, state<=HOLD.
- HOLD with fir_tready and no accept -> IDLE, fir_tvalid<=0. HOLD with fir_tready and accept -> stays HOLD, new beat (back-to-back). HOLD without fir_tready: fir_tdata/fir_tvalid stable.
- Result: on fir_res_tvalid with FIFO non-empty, pop tag t, ch_data[t]<=fir_res_tdata, ch_valid[t]<=1 for one cycle; other channels keep data.
- fir_res_tvalid with FIFO empty: result discarded, no ch_valid.
- Simultaneous push and pop: both occur, tag_count unchanged.
- Full FIFO (tag_count==TAG_DEPTH): all s_tready=0 until a pop; pending fir_tvalid beat still completes.
- Reset mid-operation: FSM to IDLE, FIFO emptied, in-flight FIR results after reset are discarded per empty-FIFO rule.

## Timing
- Reset values: s_tready=0, fir_tvalid=0, fir_tdata=0, ch_data=0, ch_valid=0, busy=0, tag_err=0, last_grant=N_CH-1 (channel 0 wins first).
- s_tready is combinational from s_tvalid, state, tag_count, fir_tready; fir_tready->s_tready path accepted.
- Input accept to fir_tvalid high: 1 cycle.
- fir_res_tvalid to ch_valid pulse: 1 cycle.
- Peak throughput one sample per cycle while fir_tready stays high.
- Fairness: with all channels valid continuously, grants cycle 0,1,2,3,0…; no channel waits more than N_CH-1 grants.

## Configuration
- MIC_ARB_TAG_CHECK_EN defined: tag_err set on fir_res_tvalid with empty FIFO, or on push attempt while full (internal assertion path); cleared only by reset.
- Undefined: tag_err tied to 0; empty-FIFO results silently discarded; no extra logic.

## Test plan
- Reset, then s_tvalid=4'b1111 with distinct samples, fir_tready=1 -> fir_tdata order ch0,ch1,ch2,ch3 on consecutive cycles, s_tready one-hot each cycle.
- fir_tready held 0 for 5 cycles with one beat pending -> fir_tdata/fir_tvalid stable, all s_tready=0, beat completes on the cycle fir_tready rises.
- Model FIR as 3-cycle delay of x>>8; feed ch2 0x123456 -> ch_valid=4'b0100 pulse, ch_data ch2 slice=0x1234, other slices unchanged.
- TAG_DEPTH=16, 16 accepts with no results -> s_tready all 0; one fir_res_tvalid -> exactly one further accept allowed.
- fir_res_tvalid with FIFO empty -> no ch_valid; tag_err=1 with MIC_ARB_TAG_CHECK_EN, 0 without.
- Assert rst_n_in low mid-HOLD with 5 tags queued -> fir_tvalid=0, busy=0 immediately; post-reset results ignored.

Source files
------------

// File: rtl/mic_fir_arbiter.sv
// Round-robin arbiter sharing one FIR across N_CH mic channels, with a tag FIFO steering results back.
// Optional: define MIC_ARB_TAG_CHECK_EN to enable the sticky tag_err flag.
module mic_fir_arbiter #(
    parameter int N_CH      = 4,
    parameter int IN_W      = 24,
    parameter int OUT_W     = 16,
    parameter int TAG_DEPTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [N_CH*IN_W-1:0]  s_tdata,
    input  logic [N_CH-1:0]       s_tvalid,
    output logic [N_CH-1:0]       s_tready,
    output logic [IN_W-1:0]       fir_tdata,
    output logic                  fir_tvalid,
    input  logic                  fir_tready,
    input  logic [OUT_W-1:0]      fir_res_tdata,
    input  logic                  fir_res_tvalid,
    output logic [N_CH*OUT_W-1:0] ch_data,
    output logic [N_CH-1:0]       ch_valid,
    output logic                  busy,
    output logic                  tag_err
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t                  r_state;
    logic [CH_W-1:0]         r_last_grant;
    logic [IN_W-1:0]         r_fir_tdata;
    logic                    r_fir_tvalid;
    logic [CH_W-1:0]         r_tags [TAG_DEPTH];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_rptr;
    logic [CNT_W-1:0]        r_count;
    logic [N_CH*OUT_W-1:0]   r_ch_data;
    logic [N_CH-1:0]         r_ch_valid;

    logic [CH_W-1:0]         w_grant;
    logic                    w_found;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_can_issue;
    logic                    w_push;
    logic                    w_pop;
    logic [CH_W-1:0]         w_tag;

    assign w_full      = (r_count == CNT_W'(TAG_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_can_issue = ((r_state == S_IDLE) || fir_tready) && !w_full;
    assign w_push      = w_found && w_can_issue;
    assign w_pop       = fir_res_tvalid && !w_empty;
    assign w_tag       = r_tags[r_rptr];

    // Descending scan so the nearest requester after last_grant is the one left assigned.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int k = N_CH; k >= 1; k--) begin
            if (s_tvalid[(int'(r_last_grant) + k) % N_CH]) begin
                w_grant = CH_W'((int'(r_last_grant) + k) % N_CH);
                w_found = 1'b1;
            end
        end
    end

    assign s_tready = w_push ? (N_CH'(1) << w_grant) : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_fir_tvalid <= 1'b0;
            r_fir_tdata  <= '0;
            r_last_grant <= CH_W'(N_CH - 1);
        end else if (w_push) begin
            r_state      <= S_HOLD;
            r_fir_tvalid <= 1'b1;
            r_fir_tdata  <= s_tdata[int'(w_grant)*IN_W +: IN_W];
            r_last_grant <= w_grant;
        end else if ((r_state == S_HOLD) && fir_tready) begin
            r_state      <= S_IDLE;
            r_fir_tvalid <= 1'b0;
        end
    end

    // Tag storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_tags[r_wptr] <= w_grant;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ch_data  <= '0;
            r_ch_valid <= '0;
        end else begin
            r_ch_valid <= '0;
            if (w_pop) begin
                r_ch_data[int'(w_tag)*OUT_W +: OUT_W] <= fir_res_tdata;
                r_ch_valid[w_tag]                     <= 1'b1;
            end
        end
    end

`ifdef MIC_ARB_TAG_CHECK_EN
    logic r_tag_err;

    // Push-while-full cannot occur through s_tready; it guards against internal corruption.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tag_err <= 1'b0;
        end else if ((fir_res_tvalid && w_empty) || (w_push && w_full)) begin
            r_tag_err <= 1'b1;
        end
    end

    assign tag_err = r_tag_err;
`else
    assign tag_err = 1'b0;
`endif

    assign fir_tdata  = r_fir_tdata;
    assign fir_tvalid = r_fir_tvalid;
    assign ch_data    = r_ch_data;
    assign ch_valid   = r_ch_valid;
    assign busy       = !w_empty || r_fir_tvalid;

endmodule

// File: tb/tb_mic_fir_arbiter.sv
// Randomized self-checking bench for mic_fir_arbiter against a queue-based reference model.
module tb_mic_fir_arbiter;

    localparam int N_CH      = 4;
    localparam int IN_W      = 24;
    localparam int OUT_W     = 16;
    localparam int TAG_DEPTH = 16;

    logic                  clk_in = 1'b0;
    logic                  rst_n_in = 1'b0;
    logic [N_CH*IN_W-1:0]  s_tdata = '0;
    logic [N_CH-1:0]       s_tvalid = '0;
    logic [N_CH-1:0]       s_tready;
    logic [IN_W-1:0]       fir_tdata;
    logic                  fir_tvalid;
    logic                  fir_tready = 1'b0;
    logic [OUT_W-1:0]      fir_res_tdata = '0;
    logic                  fir_res_tvalid = 1'b0;
    logic [N_CH*OUT_W-1:0] ch_data;
    logic [N_CH-1:0]       ch_valid;
    logic                  busy;
    logic                  tag_err;

    int checks = 0;
    int errors = 0;

    // Reference model: pending FIR beat, queue of outstanding channel ids, per-channel outputs.
    bit                    mPending;
    logic [IN_W-1:0]       mData;
    int                    mLast;
    int                    mQueue[$];
    logic [N_CH*OUT_W-1:0] mChData;
    logic [N_CH-1:0]       mChValid;
    bit                    mTagErr;

    // Behavioural FIR: 3-cycle delay of x>>8.
    bit                    pv[3];
    logic [OUT_W-1:0]      pd[3];

    mic_fir_arbiter #(
        .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .fir_tdata(fir_tdata), .fir_tvalid(fir_tvalid), .fir_tready(fir_tready),
        .fir_res_tdata(fir_res_tdata), .fir_res_tvalid(fir_res_tvalid),
        .ch_data(ch_data), .ch_valid(ch_valid), .busy(busy), .tag_err(tag_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mPending = 0;
        mData    = '0;
        mLast    = N_CH - 1;
        mQueue.delete();
        mChData  = '0;
        mChValid = '0;
        mTagErr  = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 0;
            pd[i] = '0;
        end
    endtask

    task automatic checkState();
        checkOutput("fir_tvalid", fir_tvalid, mPending);
        checkOutput("fir_tdata", fir_tdata, mData);
        checkOutput("ch_valid", ch_valid, mChValid);
        checkOutput("ch_data", ch_data, mChData);
        checkOutput("busy", busy, (mQueue.size() != 0) || mPending);
        checkOutput("tag_err", tag_err, mTagErr);
    endtask

    // One clock of stimulus: drive at negedge, check against model, then advance the model.
    task automatic applyStimulus(input logic [N_CH-1:0] tv, input logic [N_CH*IN_W-1:0] td,
                                 input logic ftr, input logic rv, input logic [OUT_W-1:0] rd);
        bit               canIssue;
        int               g;
        logic [N_CH-1:0]  expReady;
        bit               fire;
        logic [OUT_W-1:0] fireData;
        @(negedge clk_in);
        s_tvalid       = tv;
        s_tdata        = td;
        fir_tready     = ftr;
        fir_res_tvalid = rv;
        fir_res_tdata  = rd;
        #1;
        checkState();
        canIssue = (!mPending || ftr) && (mQueue.size() < TAG_DEPTH);
        g = -1;
        for (int k = 1; k <= N_CH; k++) begin
            if (g < 0 && tv[(mLast + k) % N_CH]) g = (mLast + k) % N_CH;
        end
        expReady = '0;
        if (canIssue && g >= 0) expReady[g] = 1'b1;
        checkOutput("s_tready", s_tready, expReady);

        fire     = mPending && ftr;
        fireData = mData[IN_W-1:8];
        mChValid = '0;
        if (rv) begin
            if (mQueue.size() > 0) begin
                int t;
                t = mQueue.pop_front();
                mChData[t*OUT_W +: OUT_W] = rd;
                mChValid[t] = 1'b1;
            end else begin
`ifdef MIC_ARB_TAG_CHECK_EN
                mTagErr = 1;
`endif
            end
        end
        if (expReady != '0) begin
            mQueue.push_back(g);
            mPending = 1;
            mData    = td[g*IN_W +: IN_W];
            mLast    = g;
        end else if (ftr) begin
            mPending = 0;
        end
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = fire;  pd[0] = fireData;
    endtask

    task automatic doReset();
        @(negedge clk_in);
        rst_n_in       = 1'b0;
        s_tvalid       = '0;
        fir_tready     = 1'b0;
        fir_res_tvalid = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        resetModel();
    endtask

    function automatic logic [N_CH*IN_W-1:0] distinctSamples(input int base);
        logic [N_CH*IN_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i*IN_W +: IN_W] = IN_W'(base + 24'h111111 * (i + 1));
        return v;
    endfunction

    function automatic logic [N_CH*IN_W-1:0] randomSamples();
        logic [N_CH*IN_W-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i*IN_W +: IN_W] = IN_W'($urandom);
        return v;
    endfunction

    initial begin
        logic [N_CH*IN_W-1:0] td;
        resetModel();
        doReset();

        // Reset state, then all four channels requesting: grants 0,1,2,3 back to back.
        applyStimulus('0, '0, 1'b0, 1'b0, '0);
        td = distinctSamples(0);
        for (int i = 0; i < 6; i++) applyStimulus(4'b1111, td, 1'b1, 1'b0, '0);

        // Stall with a beat pending: output stable, no accepts, then completes.
        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, td, 1'b0, 1'b0, '0);
        applyStimulus('0, td, 1'b1, 1'b0, '0);
        applyStimulus('0, td, 1'b1, 1'b0, '0);

        // Single ch2 sample routed back as 0x1234.
        doReset();
        td = '0;
        td[2*IN_W +: IN_W] = 24'h123456;
        applyStimulus(4'b0100, td, 1'b1, 1'b0, '0);
        applyStimulus('0, td, 1'b1, 1'b0, '0);
        applyStimulus('0, td, 1'b1, 1'b0, '0);
        applyStimulus('0, td, 1'b1, 1'b1, 16'h1234);
        applyStimulus('0, td, 1'b1, 1'b0, '0);
        checkOutput("ch2_valid", ch_valid, 4'b0100);
        checkOutput("ch2_data", ch_data[2*OUT_W +: OUT_W], 16'h1234);
        checkOutput("ch0_data", ch_data[0 +: OUT_W], 16'h0000);

        // Fill the tag FIFO, then one result frees exactly one slot.
        doReset();
        td = distinctSamples(5);
        for (int i = 0; i < TAG_DEPTH; i++) applyStimulus(4'b1111, td, 1'b1, 1'b0, '0);
        applyStimulus(4'b1111, td, 1'b1, 1'b0, '0);
        checkOutput("full_tready", s_tready, 4'b0000);
        applyStimulus(4'b1111, td, 1'b1, 1'b1, 16'hA5A5);
        applyStimulus(4'b1111, td, 1'b1, 1'b0, '0);
        applyStimulus(4'b1111, td, 1'b1, 1'b0, '0);
        checkOutput("refull_tready", s_tready, 4'b0000);

        // Result with empty FIFO is discarded.
        doReset();
        applyStimulus('0, '0, 1'b1, 1'b1, 16'hBEEF);
        applyStimulus('0, '0, 1'b1, 1'b0, '0);
`ifdef MIC_ARB_TAG_CHECK_EN
        checkOutput("tag_err_empty", tag_err, 1'b1);
`else
        checkOutput("tag_err_empty", tag_err, 1'b0);
`endif
        checkOutput("empty_ch_valid", ch_valid, 4'b0000);

        // Reset mid-HOLD with five tags queued.
        doReset();
        td = distinctSamples(9);
        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, td, 1'b1, 1'b0, '0);
        applyStimulus('0, td, 1'b0, 1'b0, '0);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("rst_fir_tvalid", fir_tvalid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        resetModel();
        for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b1, 1'b1, 16'h7777);
        applyStimulus('0, '0, 1'b1, 1'b0, '0);

        // Randomized traffic with the behavioural FIR plus occasional spurious results.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic             rv;
            logic [OUT_W-1:0] rd;
            rv = pv[2] || (($urandom % 32) == 0);
            rd = pv[2] ? pd[2] : OUT_W'($urandom);
            applyStimulus(N_CH'($urandom), randomSamples(), (($urandom % 4) != 0), rv, rd);
        end
        applyStimulus('0, '0, 1'b1, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
